// File: rtl/car_start_sequencer_if.sv
// Signal bundle between the safety system / driver controls and the start sequencer.
// The master side drives the vehicle inputs; the slave side is the sequencer.
interface car_start_sequencer_if;
  logic       key;
  logic       start_btn;
  logic       start_permit;
  logic       chime;
  logic       warn_pri1;
  logic       eng_run;
  logic       ign_on;
  logic       starter;
  logic       buzzer;
  logic       deny;
  logic       lockout;
  logic [2:0] state;
  logic [1:0] retry_cnt;

  modport master (
    output key, start_btn, start_permit, chime, warn_pri1, eng_run,
    input  ign_on, starter, buzzer, deny, lockout, state, retry_cnt
  );

  modport slave (
    input  key, start_btn, start_permit, chime, warn_pri1, eng_run,
    output ign_on, starter, buzzer, deny, lockout, state, retry_cnt
  );
endinterface

// File: rtl/car_start_sequencer.sv
// Engine-start controller: ignition -> timed crank -> run, with retry, cool-down and lockout.
// Also drives the cabin buzzer from the safety system's chime and priority-1 warning.
module car_start_sequencer #(
  parameter int unsigned CRANK_CYC  = 8,
  parameter int unsigned COOL_CYC   = 4,
  parameter int unsigned MAX_RETRY  = 3,  // must fit the 2-bit retry counter
  parameter int unsigned CHIME_HALF = 2
) (
  input logic                  clk,
  input logic                  rst,
  car_start_sequencer_if.slave bus
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StArmed = 3'd1;
  localparam logic [2:0] StCrank = 3'd2;
  localparam logic [2:0] StCool  = 3'd3;
  localparam logic [2:0] StRun   = 3'd4;
  localparam logic [2:0] StLock  = 3'd5;

  localparam int unsigned MaxCyc  = (CRANK_CYC > COOL_CYC) ? CRANK_CYC : COOL_CYC;
  localparam int unsigned TimerW  = $clog2(MaxCyc) + 1;
  localparam int unsigned PhaseW  = (CHIME_HALF > 1) ? $clog2(CHIME_HALF) : 1;

  localparam logic [TimerW-1:0] CrankLast = TimerW'(CRANK_CYC - 1);
  localparam logic [TimerW-1:0] CoolLast  = TimerW'(COOL_CYC - 1);
  localparam logic [PhaseW-1:0] ChimeLast = PhaseW'(CHIME_HALF - 1);
  localparam logic [1:0]        RetryMax  = 2'(MAX_RETRY);

  logic [2:0]        state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [1:0]        retry_q, retry_d;
  logic              deny_q, deny_d;
  logic              buzz_q, buzz_d;
  logic [PhaseW-1:0] chime_ph_q, chime_ph_d;
  logic              chime_lvl_q, chime_lvl_d;
  logic              btn_q;
  logic              press;
  logic              crank_ok;
  logic [1:0]        retry_inc;

  assign press     = bus.start_btn & ~btn_q;
  assign crank_ok  = bus.start_permit & ~bus.warn_pri1;
  assign retry_inc = retry_q + 2'd1;

  // Main sequencer; KEY removal overrides every state.
  always_comb begin
    state_d = state_q;
    timer_d = '0;
    retry_d = retry_q;
    deny_d  = 1'b0;

    if (!bus.key) begin
      state_d = StIdle;
      retry_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          retry_d = '0;
          state_d = StArmed;
        end

        StArmed: begin
          if (press) begin
            if (crank_ok) begin
              state_d = StCrank;
            end else begin
              deny_d = 1'b1;
            end
          end
        end

        StCrank: begin
          timer_d = timer_q + TimerW'(1);
          if (bus.eng_run) begin
            // Engine catching wins even on the last permitted crank cycle.
            state_d = StRun;
            retry_d = '0;
            timer_d = '0;
          end else if (!bus.start_permit) begin
            state_d = StArmed;
            timer_d = '0;
          end else if (timer_q == CrankLast) begin
            retry_d = retry_inc;
            timer_d = '0;
            state_d = (retry_inc == RetryMax) ? StLock : StCool;
          end
        end

        StCool: begin
          timer_d = timer_q + TimerW'(1);
          deny_d  = press;
          if (timer_q == CoolLast) begin
            state_d = StArmed;
            timer_d = '0;
          end
        end

        StRun: begin
          retry_d = '0;
          if (!bus.eng_run) begin
            state_d = StArmed;
          end
        end

        StLock: begin
          deny_d = press;
        end

        default: begin
          state_d = StIdle;
          retry_d = '0;
        end
      endcase
    end
  end

  // Chime phase runs only while CHIME is high; first toggle lands on the first CHIME cycle.
  always_comb begin
    chime_ph_d  = '0;
    chime_lvl_d = 1'b0;
    if (bus.chime) begin
      chime_lvl_d = (chime_ph_q == '0) ? ~chime_lvl_q : chime_lvl_q;
      chime_ph_d  = (chime_ph_q == ChimeLast) ? '0 : chime_ph_q + PhaseW'(1);
    end
  end

  always_comb begin
    buzz_d = 1'b0;
    if (bus.warn_pri1 && (state_q != StIdle)) begin
      buzz_d = 1'b1;
    end else if (bus.chime) begin
      buzz_d = chime_lvl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      retry_q     <= '0;
      deny_q      <= 1'b0;
      buzz_q      <= 1'b0;
      chime_ph_q  <= '0;
      chime_lvl_q <= 1'b0;
      btn_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      deny_q      <= deny_d;
      buzz_q      <= buzz_d;
      chime_ph_q  <= chime_ph_d;
      chime_lvl_q <= chime_lvl_d;
      btn_q       <= bus.start_btn;
    end
  end

  // Moore decodes of the registered state.
  always_comb begin
    bus.ign_on  = 1'b0;
    bus.starter = 1'b0;
    bus.lockout = 1'b0;
    case (state_q)
      StArmed, StCool, StRun: bus.ign_on = 1'b1;
      StCrank: begin
        bus.ign_on  = 1'b1;
        bus.starter = 1'b1;
      end
      StLock: begin
        bus.ign_on  = 1'b1;
        bus.lockout = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.buzzer    = buzz_q;
  assign bus.deny      = deny_q;
  assign bus.state     = state_q;
  assign bus.retry_cnt = retry_q;

endmodule
